// File: rtl/median_pkg.sv
// Shared constants, loader state type and slot helpers for the median filter datapath.
package median_pkg;

    localparam int unsigned DW      = 13;
    localparam int unsigned N       = 16;
    localparam int unsigned MED_IDX = 7;
    localparam int unsigned WW      = N * DW;
    localparam int unsigned CW      = $clog2(N + 1);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } loader_state_e;

    // Extract sample slot idx from a packed window bus.
    function automatic logic [DW-1:0] slot(input logic [WW-1:0] bus, input int unsigned idx);
        return bus[idx*DW +: DW];
    endfunction

    // floor((a+b)/2) with a DW+1 bit intermediate so full-scale inputs cannot wrap.
    function automatic logic [DW-1:0] med_avg(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DW:1];
    endfunction

endpackage

// File: rtl/bsort.sv
// Combinational 16-input ascending sorter (odd-even transposition network).
module bsort
    import median_pkg::*;
(
    input  logic [WW-1:0] din,
    output logic [WW-1:0] dout
);

    logic [DW-1:0] v [N];
    logic [DW-1:0] tmp;

    // N alternating compare-exchange rounds fully sort N elements; slot 0 ends smallest.
    always_comb begin
        for (int k = 0; k < int'(N); k++) begin
            v[k] = din[k*DW +: DW];
        end
        tmp = '0;
        for (int r = 0; r < int'(N); r++) begin
            for (int k = r % 2; k < int'(N) - 1; k += 2) begin
                if (v[k] > v[k+1]) begin
                    tmp    = v[k];
                    v[k]   = v[k+1];
                    v[k+1] = tmp;
                end
            end
        end
        dout = '0;
        for (int k = 0; k < int'(N); k++) begin
            dout[k*DW +: DW] = v[k];
        end
    end

endmodule

// File: rtl/bsort_stream_ctrl.sv
// Streaming loader and result stage around the combinational window sorter.
// Samples are packed into sort_in; a full window is captured from sort_out into
// the result registers while the next window starts loading.
module bsort_stream_ctrl
    import median_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic [WW-1:0] sort_in,
    input  logic [WW-1:0] sort_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WW-1:0] out_sorted,
    output logic [DW-1:0] out_min,
    output logic [DW-1:0] out_max,
    output logic [DW-1:0] out_median,
    output logic [DW-1:0] out_med_avg,
    output logic [CW-1:0] fill_cnt
);

    loader_state_e state;
    logic          accept_c;
    logic          capture_c;
    logic          drain_c;

    // Handshake decodes; in_ready is a registered copy of state==FILL.
    always_comb begin
        accept_c  = in_valid && in_ready;
        capture_c = (state == ST_FULL) && (!out_valid || out_ready);
        drain_c   = out_valid && out_ready;
    end

    // Loader FSM: writes accepted samples into their slot, then holds the full window until captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_FILL;
            in_ready <= 1'b1;
            fill_cnt <= '0;
            sort_in  <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept_c) begin
                        for (int k = 0; k < int'(N); k++) begin
                            if (fill_cnt == CW'(k)) begin
                                sort_in[k*DW +: DW] <= in_data;
                            end
                        end
                        fill_cnt <= fill_cnt + CW'(1);
                        if (fill_cnt == CW'(N - 1)) begin
                            state    <= ST_FULL;
                            in_ready <= 1'b0;
                        end
                    end
                end
                ST_FULL: begin
                    // Stale slots are left in place; the next window overwrites them in order.
                    if (capture_c) begin
                        state    <= ST_FILL;
                        in_ready <= 1'b1;
                        fill_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_FILL;
                    in_ready <= 1'b1;
                    fill_cnt <= '0;
                end
            endcase
        end
    end

    // Result stage: capture sorted window and derived statistics; hold until consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_sorted  <= '0;
            out_min     <= '0;
            out_max     <= '0;
            out_median  <= '0;
            out_med_avg <= '0;
        end else if (capture_c) begin
            out_valid   <= 1'b1;
            out_sorted  <= sort_out;
            out_min     <= slot(sort_out, 0);
            out_max     <= slot(sort_out, N - 1);
            out_median  <= slot(sort_out, MED_IDX);
            out_med_avg <= med_avg(slot(sort_out, MED_IDX), slot(sort_out, MED_IDX + 1));
        end else if (drain_c) begin
            out_valid   <= 1'b0;
        end
    end

endmodule
